// File: rtl/mfda_route_pkg.sv
// Shared types and constants for the chip flow-switch route sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mfda_route_pkg;

    localparam int NUM_SW_DEFAULT = 13;

    // Port 0 of the 3-port switch has no channel behind it.
    localparam logic [1:0] SEL_UNCONNECTED_3P = 2'd0;

    typedef logic [1:0] sw_sel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTUATE = 2'd1,
        SETTLE  = 2'd2,
        DONE    = 2'd3
    } route_state_t;

    function automatic logic id_in_range(input logic [3:0] id, input int num_sw);
        return int'(id) < num_sw;
    endfunction

endpackage

// File: rtl/switch_route_sequencer_settle_timer.sv
// Valve settle down-counter: load a start value, count down to zero, flag zero.
// Latency: count updates on the edge after load/dec; zero is combinational from the count.
// Backpressure: none; dec below zero is ignored so the counter parks at 0.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (count -> 0)
//   clr           synchronous clear (count -> 0), used on abort
//   load/load_val load the 16-bit start value
//   dec           decrement by one
//   zero          count == 0
module settle_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic        zero
);

    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != 16'd0)) begin
            count_q <= count_q - 16'd1;
        end
    end

    assign zero = (count_q == 16'd0);

endmodule

// File: rtl/switch_route_sequencer.sv
// Route sequencer: applies one switch actuate/release command, waits for valves to settle.
// Latency: accept edge to route_done-high cycle is SETTLE_CYCLES+2 cycles.
// Backpressure: cmd_ready only in IDLE with abort low; one command in flight at a time.
//
// Optional feature macro: ROUTE_CHECK_EN (reject out-of-range ids and the
// unconnected port of the 3-port switch with a one-cycle cmd_err pulse).
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_id, cmd_sel, cmd_release target switch, port, release(1)/actuate(0)
//   abort                        clear all valves and cancel the current command
//   sw_sel[2*NUM_SW-1:0]         per-switch port select, switch k at [2k+1:2k]
//   sw_en[NUM_SW-1:0]            per-switch valve pressurized
//   busy, route_done, cmd_err    status: not idle, settle complete pulse, reject pulse
module switch_route_sequencer
    import mfda_route_pkg::*;
#(
    parameter int NUM_SW        = NUM_SW_DEFAULT,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_id,
    input  logic [1:0]            cmd_sel,
    input  logic                  cmd_release,
    input  logic                  abort,
    output logic [2*NUM_SW-1:0]   sw_sel,
    output logic [NUM_SW-1:0]     sw_en,
    output logic                  busy,
    output logic                  route_done,
    output logic                  cmd_err
);

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    route_state_t state_q, state_d;

    logic [3:0] id_q;
    sw_sel_t    sel_q;
    logic       release_q;

    logic accept;
    logic cmd_ok;
    logic timer_load, timer_dec, timer_zero;

    assign cmd_ready  = (state_q == IDLE) && !abort && !rst;
    assign accept     = cmd_valid && cmd_ready;
    assign busy       = (state_q != IDLE);
    assign route_done = (state_q == DONE);

`ifdef ROUTE_CHECK_EN
    // Bad commands are still handshaken so the producer never stalls on them.
    assign cmd_ok = id_in_range(cmd_id, NUM_SW) &&
                    !(!cmd_release && (int'(cmd_id) == NUM_SW - 1) &&
                      (cmd_sel == SEL_UNCONNECTED_3P));

    logic cmd_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= accept && !cmd_ok;
        end
    end

    assign cmd_err = cmd_err_q;
`else
    assign cmd_ok  = 1'b1;
    assign cmd_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and timer controls
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && cmd_ok) begin
                    state_d = ACTUATE;
                end
            end
            ACTUATE: begin
                timer_load = 1'b1;
                state_d    = SETTLE;
            end
            SETTLE: begin
                if (timer_zero) begin
                    state_d = DONE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort skips DONE entirely, so no route_done follows it.
        if (abort) begin
            state_d    = IDLE;
            timer_load = 1'b0;
            timer_dec  = 1'b0;
        end
    end

    // Command capture and switch output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q      <= '0;
            sel_q     <= '0;
            release_q <= 1'b0;
            sw_sel    <= '0;
            sw_en     <= '0;
        end else begin
            if (accept) begin
                id_q      <= cmd_id;
                sel_q     <= cmd_sel;
                release_q <= cmd_release;
            end

            if (abort) begin
                // Selects are kept so a later re-pressurize lands on the same port.
                sw_en <= '0;
            end else if ((state_q == ACTUATE) && id_in_range(id_q, NUM_SW)) begin
                for (int k = 0; k < NUM_SW; k++) begin
                    if (int'(id_q) == k) begin
                        if (release_q) begin
                            sw_en[k] <= 1'b0;
                        end else begin
                            sw_sel[2*k +: 2] <= sel_q;
                            sw_en[k]         <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

endmodule

// File: tb/tb_switch_route_sequencer.sv
// Directed bench: instance a uses default parameters, instance b uses SETTLE_CYCLES=1.
module tb_switch_route_sequencer;

    localparam int NSW = 13;
    localparam int S   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance a
    logic              rst, cmd_valid, cmd_release, abort;
    logic [3:0]        cmd_id;
    logic [1:0]        cmd_sel;
    logic              cmd_ready, busy, route_done, cmd_err;
    logic [2*NSW-1:0]  sw_sel;
    logic [NSW-1:0]    sw_en;

    // instance b
    logic              b_rst, b_cmd_valid, b_cmd_release, b_abort;
    logic [3:0]        b_cmd_id;
    logic [1:0]        b_cmd_sel;
    logic              b_cmd_ready, b_busy, b_route_done, b_cmd_err;
    logic [2*NSW-1:0]  b_sw_sel;
    logic [NSW-1:0]    b_sw_en;

    switch_route_sequencer #(.NUM_SW(NSW), .SETTLE_CYCLES(S)) u_dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .cmd_sel(cmd_sel), .cmd_release(cmd_release),
        .abort(abort), .sw_sel(sw_sel), .sw_en(sw_en), .busy(busy),
        .route_done(route_done), .cmd_err(cmd_err)
    );

    switch_route_sequencer #(.NUM_SW(NSW), .SETTLE_CYCLES(1)) u_dut_b (
        .clk(clk), .rst(b_rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_id(b_cmd_id), .cmd_sel(b_cmd_sel), .cmd_release(b_cmd_release),
        .abort(b_abort), .sw_sel(b_sw_sel), .sw_en(b_sw_en), .busy(b_busy),
        .route_done(b_route_done), .cmd_err(b_cmd_err)
    );

    int checks = 0;
    int errors = 0;

    int d, dc, bc, ec, rb;
    int acc[3];
    int n, rbad, cnt, bd;
    bit took;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer a command on instance a; returns one cycle after the accept edge.
    task automatic send(input logic [3:0] id, input logic [1:0] sel, input logic rel);
        cmd_id      = id;
        cmd_sel     = sel;
        cmd_release = rel;
        cmd_valid   = 1'b1;
        #1;
        for (int i = 0; i < 300 && !cmd_ready; i++) tick();
        check("send_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Walk instance a until busy drops; start is the cycle index (1 = ACTUATE).
    task automatic observe(input int start, output int done_at, output int done_cnt,
                           output int busy_cnt, output int err_cnt, output int rdy_cnt);
        done_at = 0; done_cnt = 0; busy_cnt = 0; err_cnt = 0; rdy_cnt = 0;
        for (int c = start; c < start + 300; c++) begin
            if (!busy) break;
            busy_cnt++;
            if (cmd_ready) rdy_cnt++;
            if (route_done) begin
                done_cnt++;
                done_at = c;
            end
            if (cmd_err) err_cnt++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_sel = '0; cmd_release = 1'b0; abort = 1'b0;
        b_rst = 1'b1; b_cmd_valid = 1'b0; b_cmd_id = '0; b_cmd_sel = '0; b_cmd_release = 1'b0; b_abort = 1'b0;
        tick();
        tick();

        // reset state
        check("rst_sw_sel", sw_sel, 0);
        check("rst_sw_en", sw_en, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_done", route_done, 0);
        check("rst_err", cmd_err, 0);
        check("rst_b_busy", b_busy, 0);

        rst = 1'b0; b_rst = 1'b0;
        #1;
        check("post_rst_ready", cmd_ready, 1);

        // actuate id 4 port 2
        send(4'd4, 2'd2, 1'b0);
        check("act_c1_busy", busy, 1);
        check("act_c1_en", sw_en, 0);
        tick();
        check("act_sel4", sw_sel[9:8], 2);
        check("act_en4", sw_en, 13'h0010);
        observe(2, d, dc, bc, ec, rb);
        // busy covers ACTUATE, SETTLE_CYCLES settle cycles and DONE
        check("act_latency", d, S + 2);
        check("act_done_cnt", dc, 1);
        check("act_busy_cyc", bc + 1, S + 2);
        check("act_rdy_busy", rb, 0);
        check("act_err", ec, 0);

        // actuate then release id 0
        send(4'd0, 2'd3, 1'b0);
        observe(1, d, dc, bc, ec, rb);
        check("sw0_sel", sw_sel[1:0], 3);
        check("sw0_en", sw_en, 13'h0011);
        send(4'd0, 2'd1, 1'b1);
        observe(1, d, dc, bc, ec, rb);
        check("rel_latency", d, S + 2);
        check("rel_en", sw_en, 13'h0010);
        check("rel_sel_kept", sw_sel[1:0], 3);
        check("rel_other_sel", sw_sel[9:8], 2);

        // back-to-back with cmd_valid held high
        n = 0; rbad = 0;
        cmd_id = 4'd1; cmd_sel = 2'd1; cmd_release = 1'b0; cmd_valid = 1'b1;
        #1;
        for (int cyc = 0; cyc < 300 && n < 3; cyc++) begin
            took = cmd_ready;
            if (busy && cmd_ready) rbad++;
            if (took) begin
                acc[n] = cyc;
                n++;
            end
            tick();
            if (took) begin
                if (n < 3) begin
                    cmd_id  = 4'(n + 1);
                    cmd_sel = 2'(n + 1);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        observe(1, d, dc, bc, ec, rb);
        check("b2b_count", n, 3);
        check("b2b_gap1", acc[1] - acc[0], S + 3);
        check("b2b_gap2", acc[2] - acc[1], S + 3);
        check("b2b_rdy_busy", rbad + rb, 0);
        check("b2b_en", sw_en, 13'h001E);
        check("b2b_sel", sw_sel, 743);

        send(4'd4, 2'd0, 1'b1);
        observe(1, d, dc, bc, ec, rb);
        check("rel4_en", sw_en, 13'h000E);
        check("rel4_sel", sw_sel, 743);

        // abort at the 5th SETTLE cycle
        send(4'd5, 2'd1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("abt_pre_busy", busy, 1);
        check("abt_pre_en", sw_en, 13'h002E);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check("abt_en", sw_en, 0);
        check("abt_busy", busy, 0);
        check("abt_sel_kept", sw_sel, 1767);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (route_done) cnt++;
            tick();
        end
        check("abt_no_done", cnt, 0);

        // abort beats a simultaneous command
        abort = 1'b1; cmd_valid = 1'b1; cmd_id = 4'd6; cmd_sel = 2'd1; cmd_release = 1'b0;
        #1;
        check("abt_cmd_ready", cmd_ready, 0);
        tick();
        check("abt_cmd_busy", busy, 0);
        abort = 1'b0; cmd_valid = 1'b0;
        tick();
        check("abt_cmd_busy2", busy, 0);
        check("abt_cmd_sel", sw_sel, 1767);

`ifdef ROUTE_CHECK_EN
        send(4'd13, 2'd1, 1'b0);
        check("chk13_err", cmd_err, 1);
        check("chk13_busy", busy, 0);
        tick();
        check("chk13_err_end", cmd_err, 0);
        send(4'd12, 2'd0, 1'b0);
        check("chk12_err", cmd_err, 1);
        check("chk12_busy", busy, 0);
        tick();
        check("chk12_err_end", cmd_err, 0);
        check("chk_en", sw_en, 0);
        check("chk_sel", sw_sel, 1767);
`else
        send(4'd13, 2'd1, 1'b0);
        observe(1, d, dc, bc, ec, rb);
        check("oor_latency", d, S + 2);
        check("oor_done_cnt", dc, 1);
        check("oor_err", ec, 0);
        check("oor_en", sw_en, 0);
        check("oor_sel", sw_sel, 1767);
`endif

        // legal command to the 3-port switch
        send(4'd12, 2'd1, 1'b0);
        observe(1, d, dc, bc, ec, rb);
        check("sw12_en", sw_en, 13'h1000);
        check("sw12_sel", sw_sel[25:24], 1);

        // instance b: SETTLE_CYCLES = 1
        b_cmd_id = 4'd2; b_cmd_sel = 2'd1; b_cmd_valid = 1'b1;
        #1;
        check("b_ready", b_cmd_ready, 1);
        tick();
        b_cmd_valid = 1'b0;
        bd = 0;
        for (int c = 1; c <= 20; c++) begin
            if (b_route_done && bd == 0) bd = c;
            tick();
        end
        check("b_latency", bd, 3);

        b_cmd_id = 4'd3; b_cmd_sel = 2'd2; b_cmd_valid = 1'b1;
        tick();
        b_cmd_valid = 1'b0;
        tick();
        check("b_mid_busy", b_busy, 1);
        check("b_mid_en", b_sw_en, 13'h000C);
        b_rst = 1'b1;
        tick();
        check("b_rst_sel", b_sw_sel, 0);
        check("b_rst_en", b_sw_en, 0);
        check("b_rst_busy", b_busy, 0);
        check("b_rst_done", b_route_done, 0);
        check("b_rst_ready", b_cmd_ready, 0);
        check("b_rst_err", b_cmd_err, 0);
        b_rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (b_route_done) cnt++;
            tick();
        end
        check("b_no_done", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
